sha2_round_engine: RTL and testbench

SHA2_ROUND_ENGINE -- requirements
Module: sha2_round_engine

---
 rtl/sha2_round_engine_if.sv | 21 ++
 rtl/sha2_round_engine.sv | 185 ++++++++++++++++++
 tb/tb_sha2_round_engine.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha2_round_engine_if.sv
// Block handshake and digest bundle for the SHA-2 round engine.
// The master side offers message blocks and receives digests.
interface sha2_round_engine_if;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk;
  logic         first;
  logic         mode;
  logic         digest_valid;
  logic [255:0] digest;

  modport master (
    output blk_valid, blk, first, mode,
    input  blk_ready, digest_valid, digest
  );

  modport slave (
    input  blk_valid, blk, first, mode,
    output blk_ready, digest_valid, digest
  );
endinterface

// File: rtl/sha2_round_engine.sv
// SHA-256/224 compression engine, ROUNDS_PER_CLK rounds per cycle.
// Hash state is kept between blocks so messages can be chained.
module sha2_round_engine #(
  parameter int ROUNDS_PER_CLK = 1,
  parameter int WRD_SIZE       = 32
) (
  input logic               clk,
  input logic               reset,
  sha2_round_engine_if.slave bus
);

  localparam int R = ROUNDS_PER_CLK;

  if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rpc
    $error("ROUNDS_PER_CLK must be 1, 2, 4 or 8");
  end
  if (WRD_SIZE != 32) begin : g_bad_wrd
    $error("WRD_SIZE must be 32");
  end

  localparam logic [5:0] STEP = 6'(R);
  localparam logic [5:0] LAST = 6'(64 - R);

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^
           {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^
           {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^
           {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^
           {10'b0, x[31:10]};
  endfunction

  typedef enum logic [1:0] {
    IDLE, ROUND, FINAL, DONE
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic        mode_q;
  logic [31:0] h     [8];
  logic [31:0] v     [8];
  logic [31:0] w     [16];
  logic [31:0] nxt_v [8];
  logic [31:0] nxt_w [16];
  logic [31:0] sum   [8];

  // w[0] always holds W[cnt]; the window slides by R words per cycle
  always_comb begin : p_round
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    logic [31:0] ext [16+R];
    logic [5:0]  t;
    a  = v[0];
    b  = v[1];
    c  = v[2];
    d  = v[3];
    e  = v[4];
    f  = v[5];
    g  = v[6];
    hh = v[7];
    t1 = '0;
    t2 = '0;
    t  = '0;
    for (int i = 0; i < 16; i++) ext[i] = w[i];
    for (int j = 0; j < R; j++) begin
      ext[16+j] = ssig1(ext[14+j]) + ext[9+j] +
                  ssig0(ext[1+j]) + ext[j];
    end
    for (int r = 0; r < R; r++) begin
      t  = cnt + 6'(r);
      t1 = hh + bsig1(e) + ((e & f) ^ (~e & g)) +
           K[t] + ext[r];
      t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g;
      g  = f;
      f  = e;
      e  = d + t1;
      d  = c;
      c  = b;
      b  = a;
      a  = t1 + t2;
    end
    nxt_v = '{a, b, c, d, e, f, g, hh};
    for (int i = 0; i < 16; i++) nxt_w[i] = ext[i+R];
  end

  always_comb begin
    for (int i = 0; i < 8; i++) sum[i] = h[i] + v[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      mode_q           <= 1'b0;
      h                <= '{default: '0};
      v                <= '{default: '0};
      w                <= '{default: '0};
      bus.blk_ready    <= 1'b1;
      bus.digest_valid <= 1'b0;
      bus.digest       <= '0;
    end else begin
      bus.digest_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.blk_valid) begin
            state         <= ROUND;
            cnt           <= '0;
            bus.blk_ready <= 1'b0;
            for (int i = 0; i < 16; i++)
              w[i] <= bus.blk[511-32*i -: 32];
            if (bus.first) begin
              mode_q <= bus.mode;
              for (int i = 0; i < 8; i++) begin
                v[i] <= bus.mode ? IV224[i] : IV256[i];
                h[i] <= bus.mode ? IV224[i] : IV256[i];
              end
            end else begin
              v <= h;
            end
          end
        end
        ROUND: begin
          v   <= nxt_v;
          w   <= nxt_w;
          cnt <= cnt + STEP;
          if (cnt == LAST) state <= FINAL;
        end
        FINAL: begin
          h                <= sum;
          state            <= DONE;
          bus.digest_valid <= 1'b1;
          bus.digest <= {sum[0], sum[1], sum[2], sum[3],
                         sum[4], sum[5], sum[6],
                         mode_q ? 32'h0 : sum[7]};
        end
        DONE: begin
          state         <= IDLE;
          bus.blk_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha2_round_engine.sv
// Randomised and known-answer checks of the SHA-2 round engine
// against a whole-block SHA-256/224 reference model.
module tb_sha2_round_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sha2_round_engine_if b1 ();
  sha2_round_engine_if b2 ();
  sha2_round_engine_if b4 ();
  sha2_round_engine_if b8 ();

  sha2_round_engine #(.ROUNDS_PER_CLK(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1));
  sha2_round_engine #(.ROUNDS_PER_CLK(2)) dut2 (
    .clk(clk), .reset(reset), .bus(b2));
  sha2_round_engine #(.ROUNDS_PER_CLK(4)) dut4 (
    .clk(clk), .reset(reset), .bus(b4));
  sha2_round_engine #(.ROUNDS_PER_CLK(8)) dut8 (
    .clk(clk), .reset(reset), .bus(b8));

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h18};
  localparam logic [255:0] ABC256 = {
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [255:0] ABC224 = {
    32'h23097d22, 32'h3405d822, 32'h8642a477, 32'hbda255b3,
    32'h2aadbce4, 32'hbda0b3f7, 32'he36c9da7, 32'h00000000};
  localparam logic [511:0] TWO1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO2 = {480'h0, 32'h1c0};
  localparam logic [255:0] TWOD = {
    32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
    32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};

  // reference model state: chaining value and latched mode
  logic [255:0] mh;
  logic         mm;

  function automatic logic [31:0] rotr(
    input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(
    input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] s [8];
    logic [31:0] t1, t2, x, y;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      x = w[t-2];
      y = w[t-15];
      w[t] = (rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10)) + w[t-7] +
             (rotr(y, 7) ^ rotr(y, 18) ^ (y >> 3)) + w[t-16];
    end
    for (int i = 0; i < 8; i++) s[i] = hin[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25))
         + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KT[t] + w[t];
      t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22))
         + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      for (int i = 7; i > 0; i--) s[i] = s[i-1];
      s[4] = s[4] + t1;
      s[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++)
      r[255-32*i -: 32] = hin[255-32*i -: 32] + s[i];
    return r;
  endfunction

  function automatic void model_accept(
    input logic [511:0] blk, input logic first, input logic mode);
    if (first) begin
      mm = mode;
      mh = mode ? IV224 : IV256;
    end
    mh = compress(mh, blk);
  endfunction

  function automatic logic [255:0] model_digest();
    return mm ? {mh[255:32], 32'h0} : mh;
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    b1.blk_valid = 1'b0;
    b2.blk_valid = 1'b0;
    b4.blk_valid = 1'b0;
    b8.blk_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mh = '0;
    mm = 1'b0;
  endtask

  task automatic send(
    input logic [511:0] blk, input logic first, input logic mode);
    int n;
    n = 0;
    @(negedge clk);
    while (!b1.blk_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    b1.blk = blk;
    b1.first = first;
    b1.mode = mode;
    b1.blk_valid = 1'b1;
    @(posedge clk);
    #1 b1.blk_valid = 1'b0;
    model_accept(blk, first, mode);
  endtask

  // lat = negedges after the accept edge until digest_valid, -1 on timeout
  task automatic wait_done(output logic [255:0] dig, output int lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b1.digest_valid && n < 300);
    lat = b1.digest_valid ? n : -1;
    dig = b1.digest;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (b1.blk_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready got %b want 1", b1.blk_ready);
    end
    n_cmp++;
    if (b1.digest_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_valid got %b want 0", b1.digest_valid);
    end
    n_cmp++;
    if (b1.digest !== 256'h0) begin
      n_bad++;
      $display("FAIL reset_digest got %h want 0", b1.digest);
    end
  endtask

  task automatic test_abc(input logic mode);
    logic [255:0] dig, kat;
    int lat;
    kat = mode ? ABC224 : ABC256;
    send(ABC, 1'b1, mode);
    wait_done(dig, lat);
    n_cmp++;
    if (lat !== 66) begin
      n_bad++;
      $display("FAIL abc_latency m%0d got %0d want 66", mode, lat);
    end
    n_cmp++;
    if (dig !== kat) begin
      n_bad++;
      $display("FAIL abc_digest m%0d got %h want %h", mode, dig, kat);
    end
    n_cmp++;
    if (dig !== model_digest()) begin
      n_bad++;
      $display("FAIL abc_model m%0d got %h want %h",
               mode, dig, model_digest());
    end
    @(negedge clk);
    n_cmp++;
    if (b1.digest_valid !== 1'b0 || b1.blk_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL abc_after_done valid/ready got %b%b want 01",
               b1.digest_valid, b1.blk_ready);
    end
    n_cmp++;
    if (b1.digest !== kat) begin
      n_bad++;
      $display("FAIL abc_hold got %h want %h", b1.digest, kat);
    end
  endtask

  task automatic test_two_block();
    logic [255:0] dig;
    int lat;
    do_reset();
    send(TWO1, 1'b1, 1'b0);
    wait_done(dig, lat);
    n_cmp++;
    if (lat !== 66 || dig !== model_digest()) begin
      n_bad++;
      $display("FAIL two_mid got %h lat %0d want %h lat 66",
               dig, lat, model_digest());
    end
    // mode differs on a chained block and must be ignored
    send(TWO2, 1'b0, 1'b1);
    wait_done(dig, lat);
    n_cmp++;
    if (dig !== TWOD) begin
      n_bad++;
      $display("FAIL two_final got %h want %h", dig, TWOD);
    end
    n_cmp++;
    if (dig !== model_digest()) begin
      n_bad++;
      $display("FAIL two_model got %h want %h", dig, model_digest());
    end
  endtask

  task automatic test_rounds_per_clk();
    int lat [4];
    logic [255:0] dg [4];
    int want;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      lat[i] = -1;
      dg[i] = '0;
    end
    @(negedge clk);
    b1.blk = ABC; b1.first = 1'b1; b1.mode = 1'b0;
    b2.blk = ABC; b2.first = 1'b1; b2.mode = 1'b0;
    b4.blk = ABC; b4.first = 1'b1; b4.mode = 1'b0;
    b8.blk = ABC; b8.first = 1'b1; b8.mode = 1'b0;
    b1.blk_valid = 1'b1;
    b2.blk_valid = 1'b1;
    b4.blk_valid = 1'b1;
    b8.blk_valid = 1'b1;
    @(posedge clk);
    #1;
    b1.blk_valid = 1'b0;
    b2.blk_valid = 1'b0;
    b4.blk_valid = 1'b0;
    b8.blk_valid = 1'b0;
    model_accept(ABC, 1'b1, 1'b0);
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (b1.digest_valid && lat[0] < 0) begin
        lat[0] = n; dg[0] = b1.digest;
      end
      if (b2.digest_valid && lat[1] < 0) begin
        lat[1] = n; dg[1] = b2.digest;
      end
      if (b4.digest_valid && lat[2] < 0) begin
        lat[2] = n; dg[2] = b4.digest;
      end
      if (b8.digest_valid && lat[3] < 0) begin
        lat[3] = n; dg[3] = b8.digest;
      end
    end
    for (int i = 0; i < 4; i++) begin
      want = 64 / (1 << i) + 2;
      n_cmp++;
      if (lat[i] !== want) begin
        n_bad++;
        $display("FAIL rpc%0d_latency got %0d want %0d",
                 1 << i, lat[i], want);
      end
      n_cmp++;
      if (dg[i] !== ABC256) begin
        n_bad++;
        $display("FAIL rpc%0d_digest got %h want %h",
                 1 << i, dg[i], ABC256);
      end
    end
  endtask

  task automatic test_reset_mid_round();
    logic [255:0] dig;
    int lat, pulses;
    do_reset();
    send(ABC, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mh = '0;
    mm = 1'b0;
    n_cmp++;
    if (b1.blk_ready !== 1'b1 || b1.digest !== 256'h0) begin
      n_bad++;
      $display("FAIL midreset_state ready %b digest %h want 1 / 0",
               b1.blk_ready, b1.digest);
    end
    pulses = 0;
    repeat (80) begin
      @(negedge clk);
      if (b1.digest_valid) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++;
      $display("FAIL midreset_stale got %0d pulses want 0", pulses);
    end
    send(ABC, 1'b1, 1'b0);
    wait_done(dig, lat);
    n_cmp++;
    if (dig !== ABC256 || lat !== 66) begin
      n_bad++;
      $display("FAIL midreset_abc got %h lat %0d want %h lat 66",
               dig, lat, ABC256);
    end
  endtask

  task automatic test_hold_valid();
    logic [255:0] want;
    logic [511:0] acc;
    int busy_ready, early, n;
    b1.blk_valid = 1'b1;
    b1.first = 1'b1;
    for (int visit = 0; visit < 3; visit++) begin
      n = 0;
      @(negedge clk);
      while (!b1.blk_ready && n < 300) begin
        b1.blk = rand_blk();
        @(negedge clk);
        n++;
      end
      acc = rand_blk();
      b1.blk = acc;
      b1.mode = 1'($urandom_range(1));
      @(posedge clk);
      model_accept(acc, 1'b1, b1.mode);
      want = model_digest();
      busy_ready = 0;
      early = 0;
      for (int k = 1; k <= 66; k++) begin
        @(negedge clk);
        b1.blk = rand_blk();
        b1.mode = 1'($urandom_range(1));
        if (b1.blk_ready) busy_ready++;
        if (b1.digest_valid && k < 66) early++;
      end
      n_cmp++;
      if (busy_ready !== 0 || early !== 0) begin
        n_bad++;
        $display("FAIL hold_busy v%0d ready %0d early %0d want 0 0",
                 visit, busy_ready, early);
      end
      n_cmp++;
      if (b1.digest_valid !== 1'b1 || b1.digest !== want) begin
        n_bad++;
        $display("FAIL hold_digest v%0d got %b %h want 1 %h",
                 visit, b1.digest_valid, b1.digest, want);
      end
    end
    b1.blk_valid = 1'b0;
  endtask

  task automatic test_random_chain();
    logic [255:0] dig;
    logic f, m;
    int lat;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      // the first block after reset chains from zero H in SHA-256
      f = (i == 0) ? 1'b0 : 1'($urandom_range(1));
      m = 1'($urandom_range(1));
      send(rand_blk(), f, m);
      wait_done(dig, lat);
      n_cmp++;
      if (lat !== 66 || dig !== model_digest()) begin
        n_bad++;
        $display("FAIL chain%0d f%0d m%0d got %h lat %0d want %h",
                 i, f, m, dig, lat, model_digest());
      end
    end
  endtask

  initial begin
    b1.blk_valid = 1'b0; b1.blk = '0; b1.first = 1'b0; b1.mode = 1'b0;
    b2.blk_valid = 1'b0; b2.blk = '0; b2.first = 1'b0; b2.mode = 1'b0;
    b4.blk_valid = 1'b0; b4.blk = '0; b4.first = 1'b0; b4.mode = 1'b0;
    b8.blk_valid = 1'b0; b8.blk = '0; b8.first = 1'b0; b8.mode = 1'b0;
    mh = '0;
    mm = 1'b0;
    test_reset();
    test_abc(1'b0);
    test_abc(1'b1);
    test_two_block();
    test_rounds_per_clk();
    test_reset_mid_round();
    test_hold_valid();
    test_random_chain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
